// File: rtl/motor_drive_ctrl.sv
// Per-wheel H-bridge controller: synchronised line/proximity inputs, steering FSM, soft-start PWM.
// Optional: define SEARCH_REVERSE_EN to back up (reverse drive) while searching for a lost line.
module motor_drive_ctrl #(
  parameter int NSENS        = 4,
  parameter int PWM_W        = 8,
  parameter int DUTY_MAX     = 255,
  parameter int SEARCH_DUTY  = 96,
  parameter int RAMP_STEP    = 16,
  parameter int RAMP_DIV     = 256,
  parameter int LOST_TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NSENS-1:0] sens,
  input  logic             prox,
  input  logic             side,
  output logic             en,
  output logic             in1,
  output logic             in2,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_BRAKE  = 3'd0,
    ST_RUN    = 3'd1,
    ST_TURN   = 3'd2,
    ST_SEARCH = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int TMO_W = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT) : 1;
  localparam int DW    = PWM_W + 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOST_TIMEOUT - 1);
  localparam logic [DW-1:0]    STEP_X   = DW'(RAMP_STEP);
  localparam logic [DW-1:0]    RUN_X    = DW'(DUTY_MAX);
  localparam logic [DW-1:0]    SRCH_X   = DW'(SEARCH_DUTY);

  logic [NSENS-1:0] sens_meta_q, sens_sync_q;
  logic             prox_meta_q, prox_sync_q;
  state_e           state_q, state_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic [PWM_W-1:0] pwm_q;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             en_q, in1_q, in2_q;
  logic             en_d, in1_d, in2_d;

  logic             outer, any;
  logic [DW-1:0]    duty_x, tgt_x, nxt_x;

  assign outer = side ? sens_sync_q[0] : sens_sync_q[NSENS-1];
  assign any   = |sens_sync_q;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (!prox_sync_q) begin
      state_d = ST_BRAKE;
    end else begin
      case (state_q)
        ST_BRAKE:  state_d = ST_RUN;
        ST_RUN:    if (outer) state_d = ST_TURN;
                   else if (!any) state_d = ST_SEARCH;
        ST_TURN:   if (!any) state_d = ST_SEARCH;
                   else if (!outer) state_d = ST_RUN;
        ST_SEARCH: if (any) state_d = ST_RUN;
                   else if (tmo_q == TMO_LAST) state_d = ST_HALT;
        ST_HALT:   if (any) state_d = ST_RUN;
        default:   state_d = ST_BRAKE;
      endcase
    end
  end

  // Ramp toward the current state's target, clamping so a step never overshoots it.
  always_comb begin
    case (state_q)
      ST_RUN:    tgt_x = RUN_X;
      ST_SEARCH: tgt_x = SRCH_X;
      default:   tgt_x = '0;
    endcase
    duty_x = {1'b0, duty_q};
    nxt_x  = duty_x;
    if (state_d == ST_BRAKE || state_d == ST_TURN) begin
      nxt_x = '0;
    end else if (pre_q == PRE_LAST) begin
      if (duty_x < tgt_x)
        nxt_x = (tgt_x - duty_x <= STEP_X) ? tgt_x : duty_x + STEP_X;
      else if (duty_x > tgt_x)
        nxt_x = (duty_x - tgt_x <= STEP_X) ? tgt_x : duty_x - STEP_X;
    end
    duty_d = nxt_x[PWM_W-1:0];
  end

  always_comb begin
    pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    tmo_d = tmo_q;
    if (state_d == ST_SEARCH && state_q != ST_SEARCH) tmo_d = '0;
    else if (state_q == ST_SEARCH)                     tmo_d = tmo_q + 1'b1;
  end

  // Brake (1/1/1) unless actively driving with a non-zero duty.
  always_comb begin
    en_d  = 1'b1;
    in1_d = 1'b1;
    in2_d = 1'b1;
    if (duty_q != '0) begin
      case (state_q)
        ST_RUN: begin
          en_d  = (pwm_q < duty_q);
          in1_d = 1'b0;
          in2_d = 1'b1;
        end
        ST_SEARCH: begin
          en_d  = (pwm_q < duty_q);
`ifdef SEARCH_REVERSE_EN
          in1_d = 1'b1;
          in2_d = 1'b0;
`else
          in1_d = 1'b0;
          in2_d = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sens_meta_q <= '0;
      sens_sync_q <= '0;
      prox_meta_q <= 1'b0;
      prox_sync_q <= 1'b0;
      state_q     <= ST_BRAKE;
      duty_q      <= '0;
      pwm_q       <= '0;
      pre_q       <= '0;
      tmo_q       <= '0;
      en_q        <= 1'b1;
      in1_q       <= 1'b1;
      in2_q       <= 1'b1;
    end else begin
      sens_meta_q <= sens;
      sens_sync_q <= sens_meta_q;
      prox_meta_q <= prox;
      prox_sync_q <= prox_meta_q;
      state_q     <= state_d;
      duty_q      <= duty_d;
      pwm_q       <= pwm_q + 1'b1;
      pre_q       <= pre_d;
      tmo_q       <= tmo_d;
      en_q        <= en_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
    end
  end

  assign en    = en_q;
  assign in1   = in1_q;
  assign in2   = in2_q;
  assign state = state_q;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Directed bench for motor_drive_ctrl: left and right instances share one sensor bus.
// Expected SEARCH drive direction follows SEARCH_REVERSE_EN.
module tb_motor_drive_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sens  = 4'b0000;
  logic       prox  = 1'b0;
  logic       en_l, in1_l, in2_l, en_r, in1_r, in2_r;
  logic [2:0] state_l, state_r;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SEARCH_REVERSE_EN
  localparam logic [2:0] SP = 3'b010;
`else
  localparam logic [2:0] SP = 3'b001;
`endif

  always #5 clk = ~clk;

  motor_drive_ctrl #(
    .NSENS(4), .PWM_W(8), .DUTY_MAX(255), .SEARCH_DUTY(96),
    .RAMP_STEP(64), .RAMP_DIV(4), .LOST_TIMEOUT(16)
  ) u_left (
    .clk(clk), .rst_n(rst_n), .sens(sens), .prox(prox), .side(1'b0),
    .en(en_l), .in1(in1_l), .in2(in2_l), .state(state_l)
  );

  motor_drive_ctrl #(
    .NSENS(4), .PWM_W(8), .DUTY_MAX(255), .SEARCH_DUTY(96),
    .RAMP_STEP(64), .RAMP_DIV(4), .LOST_TIMEOUT(16)
  ) u_right (
    .clk(clk), .rst_n(rst_n), .sens(sens), .prox(prox), .side(1'b1),
    .en(en_r), .in1(in1_r), .in2(in2_r), .state(state_r)
  );

  typedef struct {
    logic [3:0] sens;
    logic       prox;
    int         wait_n;
    logic [2:0] st_l;
    logic [2:0] st_r;
    logic [2:0] msk_l;
    logic [2:0] out_l;
    logic [2:0] msk_r;
    logic [2:0] out_r;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      sens = vecs[i].sens;
      prox = vecs[i].prox;
      step(vecs[i].wait_n);
      check($sformatf("v%0d state_l", i), int'(state_l), int'(vecs[i].st_l));
      check($sformatf("v%0d state_r", i), int'(state_r), int'(vecs[i].st_r));
      if (vecs[i].msk_l != 3'b000)
        check($sformatf("v%0d out_l", i), int'({en_l, in1_l, in2_l} & vecs[i].msk_l),
              int'(vecs[i].out_l & vecs[i].msk_l));
      if (vecs[i].msk_r != 3'b000)
        check($sformatf("v%0d out_r", i), int'({en_r, in1_r, in2_r} & vecs[i].msk_r),
              int'(vecs[i].out_r & vecs[i].msk_r));
    end
  endtask

  // Called on the cycle RUN is entered: duty must climb 0,64,128,192,255 one step per 4 cycles.
  task automatic check_ramp(input string tag);
    int          idx  = 0;
    int          last = 0;
    logic [7:0]  prev;
    check({tag, " duty start"}, int'(u_left.duty_q), 0);
    prev = u_left.duty_q;
    for (int c = 1; c <= 40 && idx < 4; c++) begin
      step(1);
      if (c == 1) begin
        check({tag, " run duty0 out_l"}, int'({en_l, in1_l, in2_l}), 7);
        check({tag, " run duty0 out_r"}, int'({en_r, in1_r, in2_r}), 7);
      end
      if (u_left.duty_q != prev) begin
        check($sformatf("%s duty step %0d", tag, idx), int'(u_left.duty_q),
              (idx == 3) ? 255 : 64 * (idx + 1));
        if (idx > 0) check($sformatf("%s tick gap %0d", tag, idx), c - last, 4);
        last = c;
        prev = u_left.duty_q;
        idx++;
      end
    end
    check({tag, " duty steps seen"}, idx, 4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt_l;
    int cnt_r;
    int c;

    //               sens     prox  wait st_l  st_r  msk_l   out_l   msk_r   out_r
    vecs[0]  = '{4'b0010, 1'b1, 2,  3'd0, 3'd0, 3'b111, 3'b111, 3'b111, 3'b111};
    vecs[1]  = '{4'b0010, 1'b1, 1,  3'd1, 3'd1, 3'b111, 3'b111, 3'b111, 3'b111};
    vecs[2]  = '{4'b1000, 1'b1, 2,  3'd1, 3'd1, 3'b011, 3'b001, 3'b011, 3'b001};
    vecs[3]  = '{4'b1000, 1'b1, 1,  3'd2, 3'd1, 3'b011, 3'b001, 3'b011, 3'b001};
    vecs[4]  = '{4'b1000, 1'b1, 1,  3'd2, 3'd1, 3'b111, 3'b111, 3'b011, 3'b001};
    vecs[5]  = '{4'b0100, 1'b1, 3,  3'd1, 3'd1, 3'b000, 3'b000, 3'b011, 3'b001};
    vecs[6]  = '{4'b0100, 1'b1, 1,  3'd1, 3'd1, 3'b111, 3'b111, 3'b011, 3'b001};
    vecs[7]  = '{4'b0001, 1'b1, 3,  3'd1, 3'd2, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[8]  = '{4'b0001, 1'b1, 1,  3'd1, 3'd2, 3'b000, 3'b000, 3'b111, 3'b111};
    vecs[9]  = '{4'b0010, 1'b1, 3,  3'd1, 3'd1, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[10] = '{4'b0010, 1'b1, 1,  3'd1, 3'd1, 3'b000, 3'b000, 3'b111, 3'b111};
    vecs[11] = '{4'b1000, 1'b0, 3,  3'd0, 3'd0, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[12] = '{4'b1000, 1'b0, 1,  3'd0, 3'd0, 3'b111, 3'b111, 3'b111, 3'b111};
    vecs[13] = '{4'b0010, 1'b1, 3,  3'd1, 3'd1, 3'b111, 3'b111, 3'b111, 3'b111};
    vecs[14] = '{4'b0000, 1'b1, 2,  3'd1, 3'd1, 3'b011, 3'b001, 3'b011, 3'b001};
    vecs[15] = '{4'b0000, 1'b1, 1,  3'd3, 3'd3, 3'b011, 3'b001, 3'b011, 3'b001};
    vecs[16] = '{4'b0000, 1'b1, 1,  3'd3, 3'd3, 3'b011, SP,     3'b011, SP};
    vecs[17] = '{4'b0000, 1'b1, 14, 3'd3, 3'd3, 3'b011, SP,     3'b011, SP};
    vecs[18] = '{4'b0000, 1'b1, 1,  3'd4, 3'd4, 3'b011, SP,     3'b011, SP};
    vecs[19] = '{4'b0000, 1'b1, 1,  3'd4, 3'd4, 3'b111, 3'b111, 3'b111, 3'b111};
    vecs[20] = '{4'b0010, 1'b1, 3,  3'd1, 3'd1, 3'b111, 3'b111, 3'b111, 3'b111};
    vecs[21] = '{4'b0010, 1'b1, 1,  3'd1, 3'd1, 3'b011, 3'b001, 3'b011, 3'b001};

    // Power-on reset.
    step(3);
    check("reset state_l", int'(state_l), 0);
    check("reset state_r", int'(state_r), 0);
    check("reset out_l", int'({en_l, in1_l, in2_l}), 7);
    check("reset duty", int'(u_left.duty_q), 0);

    sens  = 4'b0010;
    prox  = 1'b1;
    rst_n = 1'b1;
    run_vectors(0, 1);

    // Asynchronous reset in the middle of a ramp at duty 128.
    c = 0;
    while (u_left.duty_q != 8'd128 && c < 40) begin
      step(1);
      c++;
    end
    check("reach duty 128", int'(u_left.duty_q), 128);
    #3 rst_n = 1'b0;
    #2;
    check("async rst state_l", int'(state_l), 0);
    check("async rst out_l", int'({en_l, in1_l, in2_l}), 7);
    check("async rst out_r", int'({en_r, in1_r, in2_r}), 7);
    check("async rst duty", int'(u_left.duty_q), 0);
    step(2);
    rst_n = 1'b1;
    run_vectors(0, 1);

    // Soft start to cruise, then one full PWM period at duty 255.
    check_ramp("soft");
    step(1);
    cnt_l = 0;
    cnt_r = 0;
    for (int i = 0; i < 256; i++) begin
      step(1);
      cnt_l += int'(en_l);
      cnt_r += int'(en_r);
    end
    check("cruise en_l high count", cnt_l, 255);
    check("cruise en_r high count", cnt_r, 255);
    check("cruise dir_l", int'({in1_l, in2_l}), 1);

    // Turns, side selection, obstacle priority.
    run_vectors(2, 13);
    check_ramp("restart");

    // Line lost: SEARCH, timeout to HALT, recovery.
    run_vectors(14, 21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
